// File: rtl/console_tty_writer_pkg.sv
// Shared constants for the console TTY writer: default geometry, control codes, FSM encodings.
// Build option: define CONSOLE_TTY_AUTOSCROLL_EN to scroll at the bottom row instead of wrapping.
package console_pkg;

  localparam int DEF_NUM_ROWS = 3;
  localparam int DEF_NUM_COLS = 10;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PUT    = 2'd1;
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
  localparam logic [1:0] ST_SCROLL = 2'd2;
`endif
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_tty_writer_if.sv
// Character input handshake plus text-buffer write/read port bundle for the console TTY writer.
interface console_tty_writer_if #(
  parameter int NUM_ROWS = console_pkg::DEF_NUM_ROWS,
  parameter int NUM_COLS = console_pkg::DEF_NUM_COLS
);
  localparam int AW = $clog2(NUM_ROWS * NUM_COLS);

  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [6:0]    buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [6:0]    buf_rdata;

  modport master (
    input  in_valid, in_char, buf_rdata,
    output in_ready, buf_we, buf_addr, buf_wdata, buf_raddr
  );

  modport slave (
    output in_valid, in_char, buf_rdata,
    input  in_ready, buf_we, buf_addr, buf_wdata, buf_raddr
  );
endinterface

// File: rtl/console_tty_writer.sv
// Streams characters into a row/column text buffer, handling CR/LF/BS/FF and a blank-on-reset.
// Build option: CONSOLE_TTY_AUTOSCROLL_EN enables the SCROLL state (otherwise rows wrap to 0).
module console_tty_writer
  import console_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  console_tty_writer_if.master        bus,
  output logic [$clog2(NUM_COLS)-1:0] cursor_col,
  output logic [$clog2(NUM_ROWS)-1:0] cursor_row
);
  localparam int CELLS = NUM_ROWS * NUM_COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(NUM_COLS);
  localparam int RW    = $clog2(NUM_ROWS);
  localparam logic [CW-1:0] LAST_COL  = CW'(NUM_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [6:0]    SPACE7    = CH_SPACE[6:0];

  logic          run_q;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [6:0]    char_q, char_d;
  logic          newline;
  logic [AW-1:0] cur_addr;

  assign cur_addr   = AW'(int'(row_q) * NUM_COLS + int'(col_q));
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign bus.in_ready = run_q && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    char_d  = char_q;
    newline = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_printable(bus.in_char)) begin
            char_d  = bus.in_char[6:0];
            state_d = ST_PUT;
          end else begin
            case (bus.in_char)
              CH_LF: newline = 1'b1;
              CH_CR: col_d = '0;
              CH_BS: if (col_q != '0) col_d = col_q - CW'(1);
              CH_FF: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                col_d   = '0;
                row_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_PUT: begin
        state_d = ST_IDLE;
        if (col_q == LAST_COL) newline = 1'b1;
        else                   col_d   = col_q + CW'(1);
      end
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
      ST_SCROLL,
`endif
      ST_CLEAR: begin
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A row advance off the bottom either scrolls or wraps to the top row.
    if (newline) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d = row_q + RW'(1);
      end else begin
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
        state_d = ST_SCROLL;
        cnt_d   = '0;
`else
        row_d = '0;
`endif
      end
    end
  end

`ifdef CONSOLE_TTY_AUTOSCROLL_EN
  localparam int COPY = (NUM_ROWS - 1) * NUM_COLS;
  logic [6:0] rd_q;

  // Read address runs one cell ahead of the write counter; outside SCROLL it parks on the
  // first source cell so rd_q already holds it when SCROLL starts.
  always_comb begin
    bus.buf_raddr = '0;
    if (run_q && COPY > 0) begin
      if (state_q == ST_SCROLL && int'(cnt_q) + 1 < COPY)
        bus.buf_raddr = AW'(int'(cnt_q) + 1 + NUM_COLS);
      else
        bus.buf_raddr = AW'(NUM_COLS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= bus.buf_rdata;
  end
`else
  assign bus.buf_raddr = '0;
`endif

  always_comb begin
    bus.buf_we    = 1'b0;
    bus.buf_addr  = '0;
    bus.buf_wdata = '0;
    if (run_q) begin
      case (state_q)
        ST_PUT: begin
          bus.buf_we    = 1'b1;
          bus.buf_addr  = cur_addr;
          bus.buf_wdata = char_q;
        end
        ST_CLEAR: begin
          bus.buf_we    = 1'b1;
          bus.buf_addr  = cnt_q;
          bus.buf_wdata = SPACE7;
        end
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
        ST_SCROLL: begin
          bus.buf_we    = 1'b1;
          bus.buf_addr  = cnt_q;
          bus.buf_wdata = (int'(cnt_q) < COPY) ? rd_q : SPACE7;
        end
`endif
        default: ;
      endcase
    end
  end

  // run_q holds the FSM for one cycle after reset so all outputs stay quiet until CLEAR starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      char_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        col_q   <= col_d;
        row_q   <= row_d;
        char_q  <= char_d;
      end
    end
  end

endmodule

// File: tb/tb_console_tty_writer.sv
// Self-checking bench for console_tty_writer: vector table plus hand sequences, write scoreboard.
module tb_console_tty_writer;
  import console_pkg::*;

  localparam int ROWS  = 3;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;
  localparam int TMO   = 200;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    int         col;
    int         row;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] cursor_col;
  logic [1:0] cursor_row;

  int checks = 0;
  int errors = 0;
  int ecol = 0;
  int erow = 0;
  int exp_scr [CELLS];
  logic [6:0] mem [CELLS];
  wr_t sb [$];

  always #5 clk = ~clk;

  console_tty_writer_if #(.NUM_ROWS(ROWS), .NUM_COLS(COLS)) bus ();

  console_tty_writer #(.NUM_ROWS(ROWS), .NUM_COLS(COLS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  // Text-buffer model: combinational read, write on the clock edge.
  assign bus.buf_rdata = (int'(bus.buf_raddr) < CELLS) ? mem[bus.buf_raddr] : 7'h00;
  always @(posedge clk) begin
    if (bus.buf_we === 1'b1 && int'(bus.buf_addr) < CELLS) mem[bus.buf_addr] <= bus.buf_wdata;
  end

  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1 && bus.buf_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus.buf_addr, bus.buf_wdata);
      end else begin
        w = sb.pop_front();
        if (int'(bus.buf_addr) != w.addr || int'(bus.buf_wdata) != w.data) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   bus.buf_addr, bus.buf_wdata, w.addr, w.data);
        end
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
    exp_scr[a] = d;
  endtask

  task automatic model_newline();
    ecol = 0;
    if (erow < ROWS - 1) begin
      erow++;
    end else begin
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
      for (int i = 0; i < (ROWS - 1) * COLS; i++) push_wr(i, exp_scr[i + COLS]);
      for (int i = (ROWS - 1) * COLS; i < CELLS; i++) push_wr(i, 32);
`else
      erow = 0;
`endif
    end
  endtask

  task automatic predict(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_wr(erow * COLS + ecol, int'(ch[6:0]));
      if (ecol == COLS - 1) model_newline();
      else ecol++;
    end else if (ch == CH_LF) begin
      model_newline();
    end else if (ch == CH_CR) begin
      ecol = 0;
    end else if (ch == CH_BS) begin
      if (ecol > 0) ecol--;
    end else if (ch == CH_FF) begin
      for (int i = 0; i < CELLS; i++) push_wr(i, 32);
      ecol = 0;
      erow = 0;
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check_int({name, "_col"}, int'(cursor_col), col);
    check_int({name, "_row"}, int'(cursor_row), row);
  endtask

  task automatic check_reset_outputs(input string name);
    check_int({name, "_bus"}, int'({bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.buf_raddr}), 0);
    check_int({name, "_ready"}, int'(bus.in_ready), 0);
    check_cursor(name, 0, 0);
  endtask

  // Called just after a posedge; returns after the transfer edge plus 1 time unit.
  task automatic accept_only(input logic [7:0] ch);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout char=%h", ch);
    end
    predict(ch);
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 || low >= TMO) break;
      low++;
    end
    if (low >= TMO) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout low=%0d", low);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] ch, output int low);
    accept_only(ch);
    wait_ready(low);
  endtask

  task automatic release_reset();
    int low;
    ecol = 0;
    erow = 0;
    for (int i = 0; i < CELLS; i++) push_wr(i, 32);
    rst_n = 1'b1;
    wait_ready(low);
    checks++;
    if (low < CELLS || low > CELLS + 1) begin
      errors++;
      $display("FAIL clear_busy got=%0d expected=%0d..%0d", low, CELLS, CELLS + 1);
    end
    check_cursor("clear_home", 0, 0);
    check_int("clear_pending", sb.size(), 0);
  endtask

  initial begin
    vec_t vt [14];
    int low;

    vt[0]  = '{8'h41, 1, 0};   vt[1]  = '{8'h42, 2, 0};
    vt[2]  = '{CH_CR, 0, 0};   vt[3]  = '{CH_LF, 0, 1};
    vt[4]  = '{CH_BS, 0, 1};   vt[5]  = '{8'h43, 1, 1};
    vt[6]  = '{CH_BS, 0, 1};   vt[7]  = '{8'hC1, 0, 1};
    vt[8]  = '{8'h7F, 0, 1};   vt[9]  = '{8'h1B, 0, 1};
    vt[10] = '{8'h7E, 1, 1};   vt[11] = '{8'h20, 2, 1};
    vt[12] = '{8'h09, 2, 1};   vt[13] = '{CH_FF, 0, 0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    for (int i = 0; i < CELLS; i++) mem[i] = 7'h3F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    release_reset();

    for (int i = 0; i < 14; i++) begin
      send_char(vt[i].ch, low);
      check_cursor($sformatf("vec%0d", i), vt[i].col, vt[i].row);
      check_int($sformatf("vec%0d_pending", i), sb.size(), 0);
    end

    // Ten 'X' fill row 0, 'Y' lands at the start of row 1.
    for (int i = 0; i < 10; i++) send_char(8'h58, low);
    send_char(8'h59, low);
    check_cursor("xy", 1, 1);
    check_int("xy_mem10", int'(mem[10]), 8'h59);

    // Backspace/carriage return from (1,5).
    send_char(CH_FF, low);
    for (int i = 0; i < 15; i++) send_char(8'h71, low);
    check_cursor("bs_start", 5, 1);
    send_char(CH_BS, low);
    check_cursor("bs1", 4, 1);
    send_char(CH_CR, low);
    check_cursor("cr", 0, 1);
    send_char(CH_BS, low);
    check_cursor("bs2", 0, 1);
    check_int("bscr_pending", sb.size(), 0);

    // Full screen then 'Z': scroll (or wrap) at the bottom row.
    send_char(CH_FF, low);
    for (int i = 0; i < CELLS - 1; i++) send_char(8'h30 + 8'(i % 10), low);
    send_char(8'h39, low);
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
    check_int("scroll_busy", low, CELLS + 1);
    check_cursor("scroll_cursor", 0, ROWS - 1);
    check_int("scroll_mem0", int'(mem[0]), 8'h30);
    check_int("scroll_mem19", int'(mem[19]), 8'h39);
    check_int("scroll_mem25", int'(mem[25]), 8'h20);
    send_char(8'h5A, low);
    check_int("z_mem20", int'(mem[20]), 8'h5A);
    check_cursor("z_cursor", 1, ROWS - 1);
`else
    check_int("wrap_busy", low, 1);
    check_cursor("wrap_cursor", 0, 0);
    send_char(8'h5A, low);
    check_int("z_mem0", int'(mem[0]), 8'h5A);
    check_int("z_mem29", int'(mem[29]), 8'h39);
    check_cursor("z_cursor", 1, 0);
`endif
    check_int("fill_pending", sb.size(), 0);

    // Abort a busy phase with reset on its fifth cycle.
`ifdef CONSOLE_TTY_AUTOSCROLL_EN
    send_char(CH_FF, low);
    for (int i = 0; i < CELLS - 1; i++) send_char(8'h61, low);
    accept_only(8'h62);
    @(posedge clk);
    repeat (4) @(posedge clk);
`else
    accept_only(CH_FF);
    repeat (4) @(posedge clk);
`endif
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    release_reset();

    repeat (5) @(posedge clk);
    check_int("final_pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_tty_writer.md
CONSOLE_TTY_WRITER -- requirements
Module: console_tty_writer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3, text rows in the downstream buffer.
REQ-002 SHALL have parameter NUM_COLS, default 10, text columns in the downstream buffer.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, character offered.
REQ-006 SHALL have port in_char, input, 8, character code.
REQ-007 SHALL have port in_ready, output, 1, character accepted when in_valid && in_ready at a clk edge.
REQ-008 SHALL have port buf_we, output, 1, text-buffer write strobe.
REQ-009 SHALL have port buf_addr, output, clog2(NUM_ROWS*NUM_COLS), write address (row*NUM_COLS+col).
REQ-010 SHALL have port buf_wdata, output, 7, write data.
REQ-011 SHALL have port buf_raddr, output, clog2(NUM_ROWS*NUM_COLS), read address.
REQ-012 SHALL have port buf_rdata, input, 7, combinational read data for buf_raddr, same cycle.
REQ-013 SHALL have ports cursor_col and cursor_row, output, clog2(NUM_COLS) and clog2(NUM_ROWS), current cursor.

Function
REQ-014 SHALL implement states IDLE, PUT, SCROLL and CLEAR; in_ready = (state==IDLE), combinational.
REQ-015 Accepted 0x20-0x7E SHALL produce buf_we=1, buf_addr=cursor, buf_wdata=in_char[6:0] on the next cycle (state PUT, 1 cycle), then advance the cursor.
REQ-016 Advance SHALL be col+1; at col NUM_COLS-1 it SHALL go to col 0, row+1; at the last row it SHALL enter SCROLL with the cursor at (last row, 0).
REQ-017 0x0A (LF) SHALL set col 0 and row+1, entering SCROLL at the last row; 0x0D (CR) SHALL set col 0; 0x08 (BS) SHALL decrement col if >0, with no erase and no row change.
REQ-018 0x0C (FF) SHALL enter CLEAR and home the cursor to (0,0).
REQ-019 All other codes SHALL be accepted and discarded, with no write and no cursor change.
REQ-020 In SCROLL, a counter i=0..(NUM_ROWS-1)*NUM_COLS-1 SHALL drive buf_raddr=i+NUM_COLS; the next cycle SHALL register buf_we=1, buf_addr=i, buf_wdata=buf_rdata.
REQ-021 SCROLL SHALL then write 0x20 to each last-row cell (NUM_COLS cycles) and return to IDLE; total busy time is NUM_ROWS*NUM_COLS+1 cycles.
REQ-022 In CLEAR, the block SHALL write 0x20 to addresses 0..NUM_ROWS*NUM_COLS-1, one per cycle, then return to IDLE.
REQ-023 buf_we SHALL be low in IDLE; no write SHALL ever exceed address NUM_ROWS*NUM_COLS-1.
REQ-024 in_char[7]=1 SHALL be treated as an unsupported code (discarded).

Reset
REQ-025 While rst_n=0: buf_we=0, buf_addr=0, buf_wdata=0, buf_raddr=0, cursor=(0,0), in_ready=0.
REQ-026 The first cycle after release SHALL enter CLEAR (blank screen, NUM_ROWS*NUM_COLS cycles) before in_ready rises.
REQ-027 Reset asserted mid-SCROLL/CLEAR SHALL abort immediately and restart per REQ-026.

Configuration
REQ-028 Macro CONSOLE_TTY_AUTOSCROLL_EN: defined -> behaviour per REQ-016/017/020/021.
REQ-029 CONSOLE_TTY_AUTOSCROLL_EN undefined -> the SCROLL state SHALL be absent; a row advance past the last row SHALL wrap the cursor to row 0 with no buffer writes.

Structure
REQ-030 Package console_pkg SHALL hold default NUM_ROWS/NUM_COLS, control codes (LF, CR, BS, FF, SPACE) and the state enum.
REQ-031 SHALL be a single module with no sub-module; its buf_* ports SHALL connect directly to the VGA console text-buffer write/read ports.

Verification
REQ-032 Reset release -> 30 writes of 0x20 at addresses 0..29, in_ready=0 throughout, then in_ready=1, cursor (0,0).
REQ-033 Send "AB" -> writes (0,0x41), (1,0x42); cursor (0,2).
REQ-034 Send 10x 'X' then 'Y' -> 'Y' at address 10; cursor (1,1).
REQ-035 Fill 30 chars '0'..'9' repeated, then 'Z' -> SCROLL: addresses 0..19 receive the prior rows 1..2, 20..29 = 0x20, then 'Z' at 20; in_ready low 31 cycles; with the macro undefined, 'Z' is written at address 0 instead.
REQ-036 Cursor (1,5), send BS, CR, BS -> cursor (1,4), (1,0), (1,0); no writes.
REQ-037 Assert rst_n=0 on cycle 5 of SCROLL -> outputs reset next edge; after release a full CLEAR occurs.
